// File: rtl/screen_select.sv
// screen_select: title/game/win screen FSM that switches the VGA pixel source only at frame boundaries.
module screen_select #(
  parameter int COLOR_W         = 12,
  parameter int WIN_HOLD_FRAMES = 180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] title_rgb,
  input  logic [COLOR_W-1:0] game_rgb,
  input  logic [COLOR_W-1:0] win1_rgb,
  input  logic [COLOR_W-1:0] win2_rgb,
  input  logic               in_video,
  input  logic               frame_start,
  input  logic               yes,
  input  logic               no,
  input  logic [1:0]         player_screen,
  output logic [COLOR_W-1:0] color_out,
  output logic               reset_plyrScrn,
  output logic [1:0]         screen_state
);
  localparam int HW = $clog2(WIN_HOLD_FRAMES + 1);
  typedef enum logic [1:0] {TITLE = 2'b00, GAME = 2'b01, WIN1 = 2'b10, WIN2 = 2'b11} state_t;
  state_t r_state, w_next;
  logic [HW-1:0] r_hold, w_hold_next;
  logic r_yes_pend, r_no_pend;
  logic w_yes, w_no, w_hold_done;
  logic [COLOR_W-1:0] w_src;
  // a request landing in the frame_start cycle itself still counts for that boundary
  assign w_yes       = r_yes_pend | yes;
  assign w_no        = r_no_pend | no;
  assign w_hold_done = r_hold == HW'(WIN_HOLD_FRAMES - 1);
  always_comb begin
    w_next = r_state;
    if (frame_start)
      case (r_state)
        TITLE:   w_next = w_yes ? GAME : TITLE;
        GAME:    w_next = w_no ? TITLE : player_screen == 2'b01 ? WIN1 : player_screen == 2'b10 ? WIN2 : GAME;
        default: w_next = w_no ? TITLE : w_yes ? GAME : w_hold_done ? TITLE : r_state;
      endcase
  end
  assign w_hold_next = (w_next != r_state || !r_state[1]) ? '0 : frame_start ? r_hold + HW'(1) : r_hold;
  assign w_src = r_state == TITLE ? title_rgb : r_state == GAME ? game_rgb : r_state == WIN1 ? win1_rgb : win2_rgb;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= TITLE;
      r_hold         <= '0;
      r_yes_pend     <= 1'b0;
      r_no_pend      <= 1'b0;
      color_out      <= '0;
      reset_plyrScrn <= 1'b1;
    end else begin
      r_state        <= w_next;
      r_hold         <= w_hold_next;
      r_yes_pend     <= !frame_start && w_yes;
      r_no_pend      <= !frame_start && w_no;
      color_out      <= in_video ? w_src : '0;
      reset_plyrScrn <= w_next != GAME;
    end
  end
  assign screen_state = r_state;
endmodule

// File: tb/tb_screen_select.sv
// tb_screen_select: vector table, hand sequences and randomized model check for screen_select.
module tb_screen_select;
  localparam int WHF = 3;
  logic clk = 1'b0, reset = 1'b0;
  logic [11:0] title_rgb, game_rgb, win1_rgb, win2_rgb, color_out;
  logic in_video, frame_start, yes, no, reset_plyrScrn;
  logic [1:0] player_screen, screen_state;
  int n_checks = 0, n_fail = 0;

  screen_select #(.COLOR_W(12), .WIN_HOLD_FRAMES(WHF)) dut (
    .clk(clk), .reset(reset), .title_rgb(title_rgb), .game_rgb(game_rgb),
    .win1_rgb(win1_rgb), .win2_rgb(win2_rgb), .in_video(in_video),
    .frame_start(frame_start), .yes(yes), .no(no), .player_screen(player_screen),
    .color_out(color_out), .reset_plyrScrn(reset_plyrScrn), .screen_state(screen_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst_n, fs, y, n, vid;
    logic [1:0] ps, st;
    logic rp;
    logic [11:0] col;
  } vec_t;
  vec_t tv[26];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic y, input logic n, input logic v, input logic [1:0] p);
    reset = r; frame_start = f; yes = y; no = n; in_video = v; player_screen = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: screen number, sticky requests and frames spent on a win screen
  int m_st, m_hold;
  bit m_yp, m_np, m_rp;
  logic [11:0] m_col;

  function automatic logic [11:0] pick(input int s);
    return s == 0 ? title_rgb : s == 1 ? game_rgb : s == 2 ? win1_rgb : win2_rgb;
  endfunction

  task automatic model_step();
    bit y, n;
    int nxt;
    if (!reset) begin
      m_st = 0; m_hold = 0; m_yp = 0; m_np = 0; m_rp = 1; m_col = '0;
    end else begin
      y = m_yp | yes;
      n = m_np | no;
      nxt = m_st;
      m_col = in_video ? pick(m_st) : 12'h000;
      if (frame_start) begin
        if (m_st == 0) nxt = y ? 1 : 0;
        else if (n) nxt = 0;
        else if (m_st == 1) nxt = player_screen == 2'b01 ? 2 : player_screen == 2'b10 ? 3 : 1;
        else if (y) nxt = 1;
        else if (m_hold == WHF - 1) nxt = 0;
        m_hold = (nxt == m_st && m_st >= 2) ? m_hold + 1 : 0;
        m_st = nxt;
        m_yp = 0;
        m_np = 0;
      end else begin
        m_yp = y;
        m_np = n;
      end
      m_rp = m_st != 1;
    end
  endtask

  initial begin
    title_rgb = 12'h111; game_rgb = 12'h222; win1_rgb = 12'h333; win2_rgb = 12'h444;
    drive(0, 0, 0, 0, 1, 0);
    //        rst fs y  n  vid ps     st     rp  col
    tv[0]  = '{0, 0, 0, 0, 1, 2'd0, 2'd0, 1, 12'h000};
    tv[1]  = '{1, 0, 0, 0, 1, 2'd0, 2'd0, 1, 12'h111};
    tv[2]  = '{1, 0, 1, 0, 1, 2'd0, 2'd0, 1, 12'h111};
    tv[3]  = '{1, 1, 0, 0, 1, 2'd0, 2'd1, 0, 12'h111};
    tv[4]  = '{1, 0, 0, 0, 1, 2'd0, 2'd1, 0, 12'h222};
    tv[5]  = '{1, 0, 0, 0, 0, 2'd0, 2'd1, 0, 12'h000};
    tv[6]  = '{1, 1, 0, 0, 1, 2'd3, 2'd1, 0, 12'h222};
    tv[7]  = '{1, 1, 0, 0, 1, 2'd2, 2'd3, 1, 12'h222};
    tv[8]  = '{1, 0, 0, 0, 1, 2'd1, 2'd3, 1, 12'h444};
    tv[9]  = '{1, 1, 0, 0, 1, 2'd1, 2'd3, 1, 12'h444};
    tv[10] = '{1, 1, 0, 0, 1, 2'd0, 2'd3, 1, 12'h444};
    tv[11] = '{1, 1, 0, 0, 1, 2'd0, 2'd0, 1, 12'h444};
    tv[12] = '{1, 0, 0, 0, 1, 2'd0, 2'd0, 1, 12'h111};
    tv[13] = '{1, 0, 1, 0, 1, 2'd0, 2'd0, 1, 12'h111};
    tv[14] = '{1, 1, 0, 0, 1, 2'd0, 2'd1, 0, 12'h111};
    tv[15] = '{1, 1, 0, 0, 1, 2'd1, 2'd2, 1, 12'h222};
    tv[16] = '{1, 0, 1, 0, 1, 2'd0, 2'd2, 1, 12'h333};
    tv[17] = '{1, 0, 0, 1, 1, 2'd0, 2'd2, 1, 12'h333};
    tv[18] = '{1, 1, 0, 0, 1, 2'd0, 2'd0, 1, 12'h333};
    tv[19] = '{1, 0, 0, 0, 1, 2'd0, 2'd0, 1, 12'h111};
    tv[20] = '{1, 1, 1, 0, 1, 2'd0, 2'd1, 0, 12'h111};
    tv[21] = '{1, 1, 0, 0, 1, 2'd2, 2'd3, 1, 12'h222};
    tv[22] = '{1, 0, 1, 0, 1, 2'd0, 2'd3, 1, 12'h444};
    tv[23] = '{0, 0, 1, 0, 1, 2'd0, 2'd0, 1, 12'h000};
    tv[24] = '{1, 1, 0, 0, 1, 2'd0, 2'd0, 1, 12'h111};
    tv[25] = '{1, 0, 0, 0, 1, 2'd0, 2'd0, 1, 12'h111};
    for (int i = 0; i < 26; i++) begin
      drive(tv[i].rst_n, tv[i].fs, tv[i].y, tv[i].n, tv[i].vid, tv[i].ps);
      tick();
      check($sformatf("vec%0d state", i), {10'd0, screen_state}, {10'd0, tv[i].st});
      check($sformatf("vec%0d rst_plyr", i), {11'd0, reset_plyrScrn}, {11'd0, tv[i].rp});
      check($sformatf("vec%0d color", i), color_out, tv[i].col);
    end
    // enter GAME, then five frames of a no-winner code must not leave it
    drive(1, 0, 1, 0, 1, 0); tick();
    drive(1, 1, 0, 0, 1, 0); tick();
    for (int f = 0; f < 5; f++) begin
      drive(1, 0, 0, 0, 1, 2'b11); tick(); tick(); tick();
      drive(1, 1, 0, 0, 1, 2'b11); tick();
      check($sformatf("nowin frame%0d state", f), {10'd0, screen_state}, 12'd1);
    end
    check("nowin rst_plyr", {11'd0, reset_plyrScrn}, 12'd0);
    game_rgb = 12'hFFF;
    drive(1, 0, 0, 0, 0, 2'b11); tick();
    check("blank color", color_out, 12'h000);
    game_rgb = 12'hABC;
    drive(1, 0, 0, 0, 1, 2'b11); tick();
    check("active color", color_out, 12'hABC);
    // randomized run against the model, starting from reset
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) begin
        reset = $urandom_range(0, 199) != 0;
        frame_start = $urandom_range(0, 5) == 0;
        yes = $urandom_range(0, 9) == 0;
        no = $urandom_range(0, 11) == 0;
        in_video = $urandom_range(0, 3) != 0;
        player_screen = 2'($urandom_range(0, 3));
        title_rgb = 12'($urandom); game_rgb = 12'($urandom);
        win1_rgb = 12'($urandom); win2_rgb = 12'($urandom);
      end
      model_step();
      tick();
      check("rand state", {10'd0, screen_state}, 12'(m_st));
      check("rand rst_plyr", {11'd0, reset_plyrScrn}, {11'd0, m_rp});
      check("rand color", color_out, m_col);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
